// File: rtl/binary_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3). Converts one WIDTH-bit value into three
// BCD digits in WIDTH cycles and saturates to 999 with an overflow flag for values above 999.
module binary_to_bcd_converter #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] binary_value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       hundreds_digit,
    output logic [3:0]       tens_digit,
    output logic [3:0]       units_digit
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] shift_q, shift_d;
    // Thousands nibble on top of the three BCD digits so 1000..1023 are seen, not wrapped.
    logic [15:0]      scratch_q, scratch_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [3:0]       hund_q, hund_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       units_q, units_d;
    logic             ovf_q, ovf_d;

    logic [15:0]      adjusted;
    logic             last_iter;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    always_comb begin
        adjusted  = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                     add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        last_iter = (cnt_q == CntW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StConvert;
            StConvert: if (last_iter) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        hund_d    = hund_q;
        tens_d    = tens_q;
        units_d   = units_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d   = binary_value;
                    scratch_d = '0;
                    cnt_d     = '0;
                end
            end
            StConvert: begin
                {scratch_d, shift_d} = {adjusted, shift_q} << 1;
                cnt_d = cnt_q + CntW'(1);
                // Digits are loaded from the final shifted value so they appear with done.
                if (last_iter) begin
                    if (scratch_d[15:12] != 4'd0) begin
                        hund_d  = 4'd9;
                        tens_d  = 4'd9;
                        units_d = 4'd9;
                        ovf_d   = 1'b1;
                    end else begin
                        hund_d  = scratch_d[11:8];
                        tens_d  = scratch_d[7:4];
                        units_d = scratch_d[3:0];
                        ovf_d   = 1'b0;
                    end
                end
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            hund_q    <= '0;
            tens_q    <= '0;
            units_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            hund_q    <= hund_d;
            tens_q    <= tens_d;
            units_q   <= units_d;
            ovf_q     <= ovf_d;
        end
    end

    // Outputs
    always_comb begin
        busy           = (state_q != StIdle);
        done           = (state_q == StDone);
        overflow       = ovf_q;
        hundreds_digit = hund_q;
        tens_digit     = tens_q;
        units_digit    = units_q;
    end

endmodule

// File: doc/binary_to_bcd_converter.md
BINARY_TO_BCD_CONVERTER -- requirements
Module: binary_to_bcd_converter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the binary input width; legal range 4..10.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, conversion request, sampled on clk.
REQ-005 The block SHALL have port binary_value, input, WIDTH bits, unsigned value to convert, sampled with start.
REQ-006 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit, one-cycle pulse when new digits are valid.
REQ-008 The block SHALL have port overflow, output, 1 bit, high when the last converted value exceeded 999.
REQ-009 The block SHALL have port hundreds_digit, output, 4 bits, BCD hundreds; drives led1_display_value of seven_segment_display_controller.
REQ-010 The block SHALL have port tens_digit, output, 4 bits, BCD tens; drives led2_display_value.
REQ-011 The block SHALL have port units_digit, output, 4 bits, BCD units; drives led3_display_value.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CONVERT, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch binary_value into a shift register, clear a 12-bit BCD scratch register, clear the iteration counter, and enter CONVERT next cycle.
REQ-014 In CONVERT, each cycle the block SHALL add 3 to every scratch BCD nibble >= 5, then shift {scratch, shift register} left by one bit (shift-add-3 / double dabble).
REQ-015 The iteration counter SHALL increment once per CONVERT cycle; after exactly WIDTH CONVERT cycles the FSM SHALL enter DONE.
REQ-016 The 12-bit scratch register SHALL be extended with a 4-bit thousands nibble internally so values 1000..1023 are detected rather than wrapped.
REQ-017 On entering DONE, the block SHALL load hundreds/tens/units_digit from the scratch; if thousands nibble is nonzero, it SHALL instead load 9,9,9 and set overflow=1, else clear overflow.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency SHALL be fixed: done asserts WIDTH+1 cycles after the cycle in which start was sampled high in IDLE.
REQ-020 busy SHALL be 1 in CONVERT and DONE, 0 in IDLE; busy rises the cycle after start is accepted.
REQ-021 start asserted while busy=1 SHALL be ignored with no queuing; binary_value changes during conversion SHALL have no effect.
REQ-022 start held continuously high SHALL produce back-to-back conversions, one accepted in each IDLE cycle (period WIDTH+2 cycles).
REQ-023 Digit outputs and overflow SHALL hold their last value between conversions and change only in the cycle done asserts.
REQ-024 Every output digit SHALL always be a legal BCD value 0..9.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, overflow=0, all digits=0, counter and scratch cleared.
REQ-026 reset SHALL take priority over start and over an in-progress conversion; an aborted conversion SHALL never produce done or update digits.

Verification
REQ-027 WIDTH=10, start with binary_value=0 -> done after 11 cycles, digits 0,0,0, overflow=0.
REQ-028 WIDTH=10, binary_value=255 -> digits 2,5,5; binary_value=999 -> 9,9,9, overflow=0.
REQ-029 WIDTH=10, binary_value=1023 -> digits 9,9,9, overflow=1; next conversion of 7 -> 0,0,7, overflow=0.
REQ-030 start pulsed again at cycles 3 and 10 of a conversion of 123 with binary_value=456 -> single done, digits 1,2,3.
REQ-031 reset asserted at cycle 5 of a conversion of 842 -> no done pulse, digits 0,0,0, busy=0 next cycle; fresh start converts correctly.
REQ-032 Exhaustive sweep 0..1023 with start held high -> every done matches reference decimal digits and overflow, done spacing exactly 12 cycles.
